fp_issue_scheduler: RTL and testbench
=====================================

# fp_issue_scheduler

Issue and writeback scheduler for the pipelined core with an attached multi-cycle FPU. It holds a 16-entry register scoreboard and stalls decode on any of these hazards:
- RAW or WAW hazards against an in-flight FP result;
- structural hazards on the single-outstanding FPU.

It also arbitrates the single register-file write port between the integer writeback stage and the FPU result. It sits beside the forwarding unit. FP results reach the register file through the W-stage mux, so the existing W-stage forwarding also covers them.

## Interface
Parameters:
- STARVE_LIMIT, default 8: number of consecutive blocked cycles in WBWAIT before the starvation guard forces bubbles.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- IssueValidD  in  1  valid instruction in decode.
- IssueFpD  in  1  decode instruction is an FP op.
- RegWriteD  in  1  decode instruction writes a register.
- WA3D  in  4  decode destination register.
- RA1D, RA2D  in  4  decode source registers.
- UsesRA1D, UsesRA2D  in  1  the source operand is actually read.
- RegWriteW  in  1  integer W stage writes the register file this cycle.
- FpReady  in  1  FPU can accept an op.
- FpResultValid  in  1  FPU result available; held until FpAck.
- StallF, StallD  out  1  hold fetch and decode registers.
- FlushE  out  1  insert a bubble into execute.
- FpIssue  out  1  FP op handed to the FPU this cycle.
- FpAck  out  1  FPU result consumed this cycle.
- WbSelFp  out  1  write-port mux selects the FP result.
- WA3Fp  out  4  destination register of the in-flight FP op.
- Busy  out  1  FSM not IDLE.

## Operation
FSM states:
- IDLE: no FP op outstanding.
- BUSY: an op has been issued and the FPU is computing.
- WBWAIT: the result is valid but the write port is blocked.

Transitions:
- IDLE→BUSY on FpIssue.
- BUSY→IDLE on FpAck.
- BUSY→WBWAIT on FpResultValid & RegWriteW.
- WBWAIT→IDLE on FpAck.
- FpResultValid in IDLE is ignored: no ack.

Scoreboard pending[15:0]:
- Set pending[WA3D] on FpIssue & RegWriteD.
- Clear pending[WA3Fp] on FpAck.
- A set and a clear of the same register in one cycle cannot occur, because issue requires IDLE.

Port arbitration:
- FpAck = WbSelFp = (state≠IDLE) & FpResultValid & ~RegWriteW.
- Integer writeback always has priority.

StallD hazard terms, where clr = FpAck & (reg==WA3Fp):
- RAW: UsesRAxD & pending[RAxD] & ~clr.
- WAW: IssueValidD & RegWriteD & pending[WA3D] & ~clr.
- Structural: IssueValidD & IssueFpD & (state≠IDLE | ~FpReady).
- Guard: the starvation guard term (see Configuration).

StallD is the OR of the RAW, WAW, structural and guard terms, gated by IssueValidD except for the guard term.

Derived outputs:
- StallF = StallD.
- FlushE = StallD.
- FpIssue = IssueValidD & IssueFpD & ~StallD.
- FP ops with RegWriteD=0 occupy the FPU and are acked normally, but set no pending bit.
- WA3Fp is latched from WA3D on FpIssue and holds its value until the next issue.

## Timing
- Reset, while reset_n is low:
  - all outputs are 0;
  - pending is 0, state is IDLE, WA3Fp is 0, the wait counter is 0.
- The FPU shares reset_n. Reset mid-operation discards the in-flight op and its scoreboard bit.
- All stall, issue and ack outputs are combinational in the current cycle. State, pending, WA3Fp and the counter update on the rising clk edge.
- A dependent instruction in decode proceeds in the same cycle as FpAck of its source. Forwarding from W supplies the value.
- Minimum FP op occupancy is 2 cycles: FpIssue in cycle N, FpAck earliest in cycle N+1.
- The wait counter increments each cycle in WBWAIT with RegWriteW high. It saturates at STARVE_LIMIT and clears on FpAck.

## Configuration
- SCHED_STARVE_GUARD_EN defined:
  - once the wait counter reaches STARVE_LIMIT, the guard term asserts StallD, and therefore FlushE, every cycle until FpAck;
  - this drains the pipe so that a RegWriteW=0 bubble reaches W.
- SCHED_STARVE_GUARD_EN undefined:
  - the guard term is 0 and the counter is not built;
  - the FP result waits indefinitely for a cycle with RegWriteW=0.

## Test plan
- Reset: hold reset_n low with FpResultValid=1 and IssueValidD=1 → all outputs 0. After release, state is IDLE and FpAck stays 0.
- FP issue then RAW:
  - FP op with WA3D=5 issues while FpReady=1 → FpIssue=1 and WA3Fp=5 next cycle.
  - Next decode has RA1D=5 and UsesRA1D=1 → StallD=FlushE=1 until the FpAck cycle, then 0 in that cycle.
- Structural hazard: second FP op while in BUSY, or FpReady=0 in IDLE → StallD=1 and FpIssue=0.
- Port conflict: FpResultValid=1 with RegWriteW=1 for 3 cycles → state WBWAIT and FpAck=0. RegWriteW drops → FpAck=WbSelFp=1, pending[5] clears.
- Starvation, guard built with STARVE_LIMIT=8: RegWriteW held at 1 in WBWAIT → StallD=1 from the 9th blocked cycle. Releasing RegWriteW → FpAck, then StallD drops the same cycle.
- WAW: integer op with WA3D equal to a pending register → StallD=1. An op writing a register with no pending bit in the same state → no stall.

Source files
------------

// File: rtl/fp_issue_scheduler_if.sv
// Decode/writeback control bundle between the core pipeline and the FP issue scheduler.
interface fp_issue_scheduler_if;
    logic       IssueValidD;
    logic       IssueFpD;
    logic       RegWriteD;
    logic [3:0] WA3D;
    logic [3:0] RA1D;
    logic [3:0] RA2D;
    logic       UsesRA1D;
    logic       UsesRA2D;
    logic       RegWriteW;
    logic       FpReady;
    logic       FpResultValid;
    logic       StallF;
    logic       StallD;
    logic       FlushE;
    logic       FpIssue;
    logic       FpAck;
    logic       WbSelFp;
    logic [3:0] WA3Fp;
    logic       Busy;

    modport master (
        output IssueValidD, IssueFpD, RegWriteD, WA3D, RA1D, RA2D, UsesRA1D, UsesRA2D,
               RegWriteW, FpReady, FpResultValid,
        input  StallF, StallD, FlushE, FpIssue, FpAck, WbSelFp, WA3Fp, Busy
    );

    modport slave (
        input  IssueValidD, IssueFpD, RegWriteD, WA3D, RA1D, RA2D, UsesRA1D, UsesRA2D,
               RegWriteW, FpReady, FpResultValid,
        output StallF, StallD, FlushE, FpIssue, FpAck, WbSelFp, WA3Fp, Busy
    );
endinterface

// File: rtl/fp_issue_scheduler.sv
// FP issue/writeback scheduler: 16-entry scoreboard, single-outstanding FPU, shared write port.
// Optional starvation guard enabled by defining SCHED_STARVE_GUARD_EN.
module fp_issue_scheduler #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    fp_issue_scheduler_if.slave   sif
);
    localparam int unsigned NREG = 16;
    localparam int unsigned RW   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        WBWAIT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [NREG-1:0] pending_q, pending_d;
    logic [RW-1:0]   wa3fp_q, wa3fp_d;

    logic ack, clr1, clr2, clrw;
    logic raw, waw, structural, guard, stall, issue;

    // Integer writeback owns the port; FP result takes it only on an idle W cycle.
    always_comb begin
        ack  = (state_q != IDLE) & sif.FpResultValid & ~sif.RegWriteW;
        clr1 = ack & (sif.RA1D == wa3fp_q);
        clr2 = ack & (sif.RA2D == wa3fp_q);
        clrw = ack & (sif.WA3D == wa3fp_q);
        raw  = (sif.UsesRA1D & pending_q[sif.RA1D] & ~clr1)
             | (sif.UsesRA2D & pending_q[sif.RA2D] & ~clr2);
        waw  = sif.RegWriteD & pending_q[sif.WA3D] & ~clrw;
        structural = sif.IssueFpD & ((state_q != IDLE) | ~sif.FpReady);
        stall = (sif.IssueValidD & (raw | waw | structural)) | guard;
        issue = sif.IssueValidD & sif.IssueFpD & ~stall;
    end

`ifdef SCHED_STARVE_GUARD_EN
    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Once saturated, keep flushing until a bubble reaches W and the result drains.
    always_comb begin
        guard      = (state_q == WBWAIT) & (wait_cnt_q == CNT_MAX) & ~ack;
        wait_cnt_d = wait_cnt_q;
        if (ack) begin
            wait_cnt_d = '0;
        end else if ((state_q == WBWAIT) && sif.RegWriteW && (wait_cnt_q != CNT_MAX)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^32'(STARVE_LIMIT);
    assign guard = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        wa3fp_d   = wa3fp_q;
        case (state_q)
            IDLE:    if (issue) state_d = BUSY;
            BUSY: begin
                if (ack) begin
                    state_d = IDLE;
                end else if (sif.FpResultValid && sif.RegWriteW) begin
                    state_d = WBWAIT;
                end
            end
            WBWAIT:  if (ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Issue only happens in IDLE, so set and clear never target the same op.
        if (issue) begin
            wa3fp_d = sif.WA3D;
            if (sif.RegWriteD) pending_d[sif.WA3D] = 1'b1;
        end
        if (ack) pending_d[wa3fp_q] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            wa3fp_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            wa3fp_q   <= wa3fp_d;
        end
    end

    // Combinational handshakes are forced quiet while reset is held.
    always_comb begin
        sif.StallF  = stall & reset_n;
        sif.StallD  = stall & reset_n;
        sif.FlushE  = stall & reset_n;
        sif.FpIssue = issue & reset_n;
        sif.FpAck   = ack & reset_n;
        sif.WbSelFp = ack & reset_n;
        sif.WA3Fp   = wa3fp_q;
        sif.Busy    = (state_q != IDLE);
    end
endmodule

// File: tb/tb_fp_issue_scheduler.sv
// Self-checking bench for fp_issue_scheduler: directed vector table, corner sequences, random vs model.
module tb_fp_issue_scheduler;
`ifdef SCHED_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int LIMIT = 8;

    logic clk = 1'b0;
    logic reset_n;
    int   vectors = 0;
    int   miscompares = 0;

    fp_issue_scheduler_if bus ();

    fp_issue_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sif     (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv, fp, rwd;
        logic [3:0] wa3, ra1, ra2;
        logic       u1, u2, rww, rdy, rv;
        logic       stall, issue, ack;
        logic [3:0] wa3fp;
        logic       busy;
    } vec_t;

    vec_t tbl [19];

    // Behavioural model: in-flight op, its destination, pending set, blocked-cycle count.
    bit       m_out, m_wait;
    bit [3:0] m_dest;
    bit       m_pend [16];
    int       m_blk;
    bit       e_stall, e_issue, e_ack;

    function automatic vec_t mk(input logic iv, fp, rwd, input logic [3:0] wa3, ra1, ra2,
                                input logic u1, u2, rww, rdy, rv,
                                input logic st, is, ak, input logic [3:0] wf, input logic bz);
        vec_t v;
        v.iv = iv; v.fp = fp; v.rwd = rwd; v.wa3 = wa3; v.ra1 = ra1; v.ra2 = ra2;
        v.u1 = u1; v.u2 = u2; v.rww = rww; v.rdy = rdy; v.rv = rv;
        v.stall = st; v.issue = is; v.ack = ak; v.wa3fp = wf; v.busy = bz;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.IssueValidD = v.iv; bus.IssueFpD = v.fp; bus.RegWriteD = v.rwd;
        bus.WA3D = v.wa3; bus.RA1D = v.ra1; bus.RA2D = v.ra2;
        bus.UsesRA1D = v.u1; bus.UsesRA2D = v.u2;
        bus.RegWriteW = v.rww; bus.FpReady = v.rdy; bus.FpResultValid = v.rv;
    endtask

    task automatic check(input string name, input logic st, is, ak, input logic [3:0] wf,
                         input logic bz);
        logic [10:0] act, exp;
        act = {bus.StallF, bus.StallD, bus.FlushE, bus.FpIssue, bus.FpAck, bus.WbSelFp,
               bus.WA3Fp, bus.Busy};
        exp = {st, st, st, is, ak, ak, wf, bz};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got {StallF,StallD,FlushE,FpIssue,FpAck,WbSelFp,WA3Fp,Busy}=%b expected %b",
                     name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_wait = 0; m_dest = '0; m_blk = 0;
        for (int i = 0; i < 16; i++) m_pend[i] = 0;
    endtask

    function automatic bit blocks(input bit [3:0] r);
        return m_pend[r] && !(e_ack && r == m_dest);
    endfunction

    task automatic model_eval();
        bit hz, g;
        e_ack = m_out && bus.FpResultValid && !bus.RegWriteW;
        hz = (bus.UsesRA1D && blocks(bus.RA1D)) || (bus.UsesRA2D && blocks(bus.RA2D))
          || (bus.RegWriteD && blocks(bus.WA3D))
          || (bus.IssueFpD && (m_out || !bus.FpReady));
        g = GUARD && m_wait && (m_blk >= LIMIT) && !e_ack;
        e_stall = (bus.IssueValidD && hz) || g;
        e_issue = bus.IssueValidD && bus.IssueFpD && !e_stall;
    endtask

    task automatic model_update();
        if (e_issue) begin
            m_out = 1; m_wait = 0; m_blk = 0; m_dest = bus.WA3D;
            if (bus.RegWriteD) m_pend[bus.WA3D] = 1;
        end else if (e_ack) begin
            m_out = 0; m_wait = 0; m_blk = 0; m_pend[m_dest] = 0;
        end else if (m_out && m_wait && bus.RegWriteW) begin
            if (m_blk < LIMIT) m_blk++;
        end else if (m_out && bus.FpResultValid && bus.RegWriteW) begin
            m_wait = 1;
        end
    endtask

    initial begin
        vec_t v;
        bit   heavy, prev_rv;

        //           iv fp rwd wa3 ra1 ra2 u1 u2 rww rdy rv | st is ak wf bz
        tbl[0]  = mk(1, 1, 1, 5, 0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0);
        tbl[1]  = mk(1, 0, 1, 2, 5, 0, 1, 0, 0, 1, 0,  1, 0, 0, 5, 1);
        tbl[2]  = mk(1, 0, 1, 2, 5, 0, 1, 0, 1, 1, 1,  1, 0, 0, 5, 1);
        tbl[3]  = mk(1, 0, 1, 2, 5, 0, 1, 0, 1, 1, 1,  1, 0, 0, 5, 1);
        tbl[4]  = mk(1, 0, 1, 2, 5, 0, 1, 0, 1, 1, 1,  1, 0, 0, 5, 1);
        tbl[5]  = mk(1, 0, 1, 2, 5, 0, 1, 0, 0, 1, 1,  0, 0, 1, 5, 1);
        tbl[6]  = mk(1, 0, 1, 2, 5, 0, 1, 0, 0, 1, 0,  0, 0, 0, 5, 0);
        tbl[7]  = mk(1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 5, 0);
        tbl[8]  = mk(1, 1, 1, 9, 0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 5, 0);
        tbl[9]  = mk(1, 1, 1, 3, 0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 9, 1);
        tbl[10] = mk(1, 0, 1, 9, 0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 9, 1);
        tbl[11] = mk(1, 0, 1, 4, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 9, 1);
        tbl[12] = mk(1, 0, 0, 0, 0, 9, 0, 1, 0, 1, 0,  1, 0, 0, 9, 1);
        tbl[13] = mk(1, 0, 1, 9, 0, 0, 0, 0, 0, 1, 1,  0, 0, 1, 9, 1);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 9, 0);
        tbl[15] = mk(1, 1, 0, 7, 0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 9, 0);
        tbl[16] = mk(1, 0, 0, 0, 7, 0, 1, 0, 0, 1, 0,  0, 0, 0, 7, 1);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 1, 7, 1);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 7, 0);

        // Reset held with live-looking inputs: every output must stay low.
        reset_n = 1'b0;
        drive(mk(1, 1, 1, 3, 3, 3, 1, 1, 0, 0, 1,  0, 0, 0, 0, 0));
        @(negedge clk); #1 check("reset_a", 0, 0, 0, 0, 0);
        @(negedge clk); #1 check("reset_b", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0));
        #1 check("idle_rv_ignored", 0, 0, 0, 0, 0);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1 check($sformatf("tbl%0d", i), tbl[i].stall, tbl[i].issue, tbl[i].ack,
                     tbl[i].wa3fp, tbl[i].busy);
        end

        // Reset mid-operation drops the in-flight op and its scoreboard bit.
        @(negedge clk);
        drive(mk(1, 1, 1, 12, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0));
        #1 check("midop_issue", 0, 1, 0, 7, 0);
        @(negedge clk);
        reset_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0));
        #1 check("midop_reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(mk(1, 0, 0, 0, 12, 0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0));
        #1 check("midop_cleared", 0, 0, 0, 0, 0);

        // Starvation: write port held by integer writeback.
        @(negedge clk);
        drive(mk(1, 1, 1, 6, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0));
        #1 check("starve_issue", 0, 1, 0, 0, 0);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1,  0, 0, 0, 0, 0));
        #1 check("starve_busy_blocked", 0, 0, 0, 6, 1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            #1 check($sformatf("starve_wb%0d", k), GUARD && (k >= LIMIT + 1), 0, 0, 6, 1);
        end
        @(negedge clk);
        bus.RegWriteW = 1'b0;
        #1 check("starve_release", 0, 0, 1, 6, 1);
        @(negedge clk);
        bus.FpResultValid = 1'b0;
        #1 check("starve_idle", 0, 0, 0, 6, 0);

        // Random traffic against the model, bench acting as the FPU.
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        heavy = 0;
        prev_rv = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c % 64 == 0) heavy = ($urandom_range(0, 2) == 0);
            v.iv  = ($urandom_range(0, 3) != 0);
            v.fp  = ($urandom_range(0, 4) < 2);
            v.rwd = ($urandom_range(0, 3) != 0);
            v.wa3 = 4'($urandom_range(0, 5));
            v.ra1 = 4'($urandom_range(0, 5));
            v.ra2 = 4'($urandom_range(0, 15));
            v.u1  = $urandom_range(0, 1) == 1;
            v.u2  = $urandom_range(0, 1) == 1;
            v.rww = heavy ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 1) == 1);
            v.rdy = ($urandom_range(0, 4) != 0);
            if (m_out) v.rv = prev_rv || ($urandom_range(0, 2) == 0);
            else       v.rv = ($urandom_range(0, 15) == 0);
            drive(v);
            #1;
            model_eval();
            check("rand", e_stall, e_issue, e_ack, m_dest, m_out);
            prev_rv = v.rv && m_out && !e_ack;
            model_update();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
